// File: rtl/store_rmw_merger.sv
// -----------------------------------------------------------------------------
// store_rmw_merger
//
// Performs SB/SH/SW stores into a word-wide data RAM that has no byte enables.
// Word stores are written straight through; byte and halfword stores read the
// addressed word, merge the new lane(s) in, and write the whole word back.
// Sits between the MEM stage and the data RAM and stalls the pipeline through
// `busy` while a store is in flight.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   store request handshake (accept on valid & ready)
//   req_addr          byte address of the store
//   req_data          right-aligned store data
//   req_select        size code shared with the load path
//                     (001/100 half, 010/011 byte, others word)
//   busy              pipeline stall, high whenever the FSM is not IDLE
//   done              one-cycle pulse in the cycle the RAM write is issued
//   misalign          one-cycle pulse when a request is rejected
//   mem_addr          word address to the RAM (0 while IDLE)
//   mem_rd_en         read strobe, RAM answers on mem_rdata one cycle later
//   mem_rdata         read data from the RAM
//   mem_wr_en         write strobe
//   mem_wdata         write data
//
// States
//   state | meaning
//   IDLE  | ready for a new request
//   READ  | read strobe issued for the word being modified
//   WAIT  | read data arriving, lanes merged into the write-data register
//   WRITE | write strobe and done issued
//   ERR   | misaligned request rejected, misalign pulse issued
// -----------------------------------------------------------------------------
module store_rmw_merger #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    input  logic [2:0]            req_select,
    output logic                  busy,
    output logic                  done,
    output logic                  misalign,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [31:0]           mem_rdata,
    output logic                  mem_wr_en,
    output logic [31:0]           mem_wdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_t;

    state_t      state;
    size_t       size_q;
    logic [1:0]  lane_q;
    // Only the low half of the store data is needed after accept: word stores
    // move their full data straight into mem_wdata at the accept edge.
    logic [15:0] data_q;

    size_t       req_size;
    logic        req_misaligned;
    logic [31:0] merged_word;

    function automatic size_t decode_size(input logic [2:0] sel);
        size_t sz;
        case (sel)
            3'b001, 3'b100: sz = SZ_HALF;
            3'b010, 3'b011: sz = SZ_BYTE;
            default:        sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Little-endian lane replacement; untouched lanes come from the RAM word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] rdata,
                                                input logic [15:0] wdata,
                                                input size_t       sz,
                                                input logic [1:0]  lane);
        logic [31:0] w;
        w = rdata;
        case (sz)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    w[7:0]   = wdata[7:0];
                    2'd1:    w[15:8]  = wdata[7:0];
                    2'd2:    w[23:16] = wdata[7:0];
                    default: w[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    w[31:16] = wdata;
                end else begin
                    w[15:0] = wdata;
                end
            end
            default: w = rdata;
        endcase
        return w;
    endfunction

    always_comb begin
        req_size       = decode_size(req_select);
        req_misaligned = is_misaligned(req_size, req_addr[1:0]);
        merged_word    = merge_lanes(mem_rdata, data_q, size_q, lane_q);
    end

    assign req_ready = (state == IDLE) & ~rst;
    assign busy      = (state != IDLE);

    // All strobes are registered and set on the edge that enters the state in
    // which they must be visible, so each one lines up with its state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            size_q    <= SZ_WORD;
            lane_q    <= 2'b00;
            data_q    <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            done      <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q <= req_size;
                        lane_q <= req_addr[1:0];
                        data_q <= req_data[15:0];
                        if (req_misaligned) begin
                            state    <= ERR;
                            misalign <= 1'b1;
                        end else if (req_size == SZ_WORD) begin
                            state     <= WRITE;
                            mem_addr  <= req_addr[ADDR_WIDTH-1:2];
                            mem_wr_en <= 1'b1;
                            mem_wdata <= req_data;
                            done      <= 1'b1;
                        end else begin
                            state     <= READ;
                            mem_addr  <= req_addr[ADDR_WIDTH-1:2];
                            mem_rd_en <= 1'b1;
                        end
                    end
                end

                READ: begin
                    mem_rd_en <= 1'b0;
                    state     <= WAIT;
                end

                // mem_rdata is valid this cycle; the merge result becomes the
                // write data presented in WRITE.
                WAIT: begin
                    mem_wdata <= merged_word;
                    mem_wr_en <= 1'b1;
                    done      <= 1'b1;
                    state     <= WRITE;
                end

                WRITE: begin
                    mem_wr_en <= 1'b0;
                    done      <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    state     <= IDLE;
                end

                ERR: begin
                    misalign <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    mem_rd_en <= 1'b0;
                    mem_wr_en <= 1'b0;
                    done      <= 1'b0;
                    misalign  <= 1'b0;
                    mem_addr  <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
